// File: rtl/bulk_ep_mux.sv
// bulk_ep_mux
//   Routes the transaction layer's single bulk IN/OUT port to one of NUM_EP
//   bulk endpoint FIFOs. The endpoint is latched for the whole transfer.
//   For OUT transfers, the level-framed byte stream is turned into AXIS with
//   tlast on the final byte.
// Ports
//   clk, rst                        : USB clock, synchronous active-high reset
//   blk_xfer_endpoint               : endpoint number of the current token
//   tlp_blk_in_xfer / _out_xfer     : IN / OUT transfer active (levels)
//   tlp_blk_xfer_in_*               : IN AXIS toward the transaction layer, plus has_data
//   tlp_blk_xfer_out_*              : OUT byte strobe/data from the transaction layer, plus ready_read
//   ep_in_*                         : per-endpoint IN grants, status and AXIS
//   ep_out_*                        : per-endpoint OUT grants, status and AXIS (shared tdata)
//   out_overrun_o                   : sticky, set when an OUT byte is lost to backpressure
module bulk_ep_mux #(
  parameter int NUM_EP  = 2,
  parameter int EP_BASE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            blk_xfer_endpoint,
  input  logic                  tlp_blk_in_xfer,
  output logic                  tlp_blk_xfer_in_has_data,
  output logic                  tlp_blk_xfer_in_data_valid,
  input  logic                  tlp_blk_xfer_in_data_ready,
  output logic                  tlp_blk_xfer_in_data_last,
  output logic [7:0]            tlp_blk_xfer_in_data,
  input  logic                  tlp_blk_out_xfer,
  output logic                  tlp_blk_xfer_out_ready_read,
  input  logic [7:0]            tlp_blk_xfer_out_data,
  input  logic                  tlp_blk_xfer_out_data_valid,
  output logic [NUM_EP-1:0]     ep_in_xfer,
  input  logic [NUM_EP-1:0]     ep_in_has_data,
  input  logic [NUM_EP-1:0]     ep_in_tvalid,
  input  logic [NUM_EP-1:0]     ep_in_tlast,
  output logic [NUM_EP-1:0]     ep_in_tready,
  input  logic [8*NUM_EP-1:0]   ep_in_tdata,
  output logic [NUM_EP-1:0]     ep_out_xfer,
  input  logic [NUM_EP-1:0]     ep_out_ready_read,
  output logic [NUM_EP-1:0]     ep_out_tvalid,
  output logic [NUM_EP-1:0]     ep_out_tlast,
  input  logic [NUM_EP-1:0]     ep_out_tready,
  output logic [7:0]            ep_out_tdata,
  output logic                  out_overrun_o
);

  localparam int SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  typedef enum logic [2:0] {IDLE, IN_XFER, OUT_XFER, OUT_FLUSH, DROP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [7:0]       beat_data_q, beat_data_d;
  logic             beat_v_q, beat_v_d;
  logic             beat_last_q, beat_last_d;
  logic             overrun_q, overrun_d;

  // Endpoint decode
  logic [3:0]        idx;
  logic              mapped;
  logic [NUM_EP-1:0] idx_oh;
  logic [NUM_EP-1:0] sel_oh;

  assign idx    = blk_xfer_endpoint - 4'(EP_BASE);
  assign mapped = ({1'b0, blk_xfer_endpoint} >= 5'(EP_BASE)) &&
                  ({1'b0, blk_xfer_endpoint} <  5'(EP_BASE + NUM_EP));

  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_onehot
    assign idx_oh[gi] = mapped && (idx == 4'(gi));
    assign sel_oh[gi] = (sel_q == SEL_W'(gi));
  end

  assign tlp_blk_xfer_in_has_data    = |(ep_in_has_data & idx_oh);
  assign tlp_blk_xfer_out_ready_read = |(ep_out_ready_read & idx_oh);

  // Selected-lane views
  logic       in_tvalid_sel, in_tlast_sel, out_tready_sel;
  logic [7:0] in_tdata_sel;

  assign in_tvalid_sel  = |(ep_in_tvalid & sel_oh);
  assign in_tlast_sel   = |(ep_in_tlast & sel_oh);
  assign out_tready_sel = |(ep_out_tready & sel_oh);

  always_comb begin
    in_tdata_sel = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      if (sel_oh[k]) in_tdata_sel = ep_in_tdata[8*k +: 8];
    end
  end

  logic in_act;
  assign in_act = (state_q == IN_XFER);

  assign tlp_blk_xfer_in_data_valid = in_act && in_tvalid_sel;
  assign tlp_blk_xfer_in_data_last  = in_act && in_tlast_sel;
  assign tlp_blk_xfer_in_data       = in_act ? in_tdata_sel : 8'h00;
  assign ep_in_tready  = (in_act && tlp_blk_xfer_in_data_ready) ? sel_oh : '0;
  assign ep_in_xfer    = in_act ? sel_oh : '0;
  assign ep_out_xfer   = (state_q == OUT_XFER) ? sel_oh : '0;
  assign ep_out_tvalid = beat_v_q ? sel_oh : '0;
  assign ep_out_tlast  = (beat_v_q && beat_last_q) ? sel_oh : '0;
  assign ep_out_tdata  = beat_data_q;
  assign out_overrun_o = overrun_q;

  // A presented beat that the endpoint will not take at this edge.
  logic beat_busy, beat_accept;
  assign beat_busy   = beat_v_q && !out_tready_sel;
  assign beat_accept = beat_v_q && out_tready_sel;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    beat_data_d = beat_data_q;
    beat_v_d    = beat_v_q;
    beat_last_d = beat_last_q;
    overrun_d   = overrun_q;

    if (beat_accept) begin
      beat_v_d    = 1'b0;
      beat_last_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tlp_blk_in_xfer && mapped) begin
          state_d = IN_XFER;
          sel_d   = idx[SEL_W-1:0];
        end else if (tlp_blk_out_xfer && mapped) begin
          state_d = OUT_XFER;
          sel_d   = idx[SEL_W-1:0];
        end else if (tlp_blk_in_xfer || tlp_blk_out_xfer) begin
          state_d = DROP;
          sel_d   = '0;
        end
      end
      IN_XFER: begin
        if (!tlp_blk_in_xfer) state_d = IDLE;
      end
      OUT_XFER: begin
        if (!tlp_blk_out_xfer) begin
          if (hold_v_q) begin
            state_d = OUT_FLUSH;
            // Present the final byte right away when the beat slot is free so
            // tlast shows one cycle after the transfer ends.
            if (!beat_busy) begin
              beat_data_d = hold_q;
              beat_v_d    = 1'b1;
              beat_last_d = 1'b1;
              hold_v_d    = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end else if (tlp_blk_xfer_out_data_valid) begin
          if (beat_busy) begin
            // Previous beat still pending: the held byte is lost.
            overrun_d = 1'b1;
          end else if (hold_v_q) begin
            beat_data_d = hold_q;
            beat_v_d    = 1'b1;
            beat_last_d = 1'b0;
          end
          hold_d   = tlp_blk_xfer_out_data;
          hold_v_d = 1'b1;
        end
      end
      OUT_FLUSH: begin
        if (hold_v_q) begin
          if (!beat_busy) begin
            beat_data_d = hold_q;
            beat_v_d    = 1'b1;
            beat_last_d = 1'b1;
            hold_v_d    = 1'b0;
          end
        end else if (!beat_v_q || out_tready_sel) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!tlp_blk_in_xfer && !tlp_blk_out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      hold_q      <= 8'h00;
      hold_v_q    <= 1'b0;
      beat_data_q <= 8'h00;
      beat_v_q    <= 1'b0;
      beat_last_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      beat_data_q <= beat_data_d;
      beat_v_q    <= beat_v_d;
      beat_last_q <= beat_last_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_bulk_ep_mux.sv
// tb_bulk_ep_mux
//   Scoreboard bench for bulk_ep_mux with NUM_EP=2, EP_BASE=1.
//   Expected IN bytes (toward the transaction layer) and OUT beats (toward the
//   endpoints) are queued when stimulus is driven and checked on handshake.
module tb_bulk_ep_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  blk_xfer_endpoint;
  logic        tlp_blk_in_xfer;
  logic        tlp_blk_xfer_in_has_data;
  logic        tlp_blk_xfer_in_data_valid;
  logic        tlp_blk_xfer_in_data_ready;
  logic        tlp_blk_xfer_in_data_last;
  logic [7:0]  tlp_blk_xfer_in_data;
  logic        tlp_blk_out_xfer;
  logic        tlp_blk_xfer_out_ready_read;
  logic [7:0]  tlp_blk_xfer_out_data;
  logic        tlp_blk_xfer_out_data_valid;
  logic [1:0]  ep_in_xfer;
  logic [1:0]  ep_in_has_data;
  logic [1:0]  ep_in_tvalid = 2'b00;
  logic [1:0]  ep_in_tlast  = 2'b00;
  logic [1:0]  ep_in_tready;
  logic [15:0] ep_in_tdata  = 16'h0000;
  logic [1:0]  ep_out_xfer;
  logic [1:0]  ep_out_ready_read;
  logic [1:0]  ep_out_tvalid;
  logic [1:0]  ep_out_tlast;
  logic [1:0]  ep_out_tready;
  logic [7:0]  ep_out_tdata;
  logic        out_overrun_o;

  bulk_ep_mux #(.NUM_EP(2), .EP_BASE(1)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .blk_xfer_endpoint           (blk_xfer_endpoint),
    .tlp_blk_in_xfer             (tlp_blk_in_xfer),
    .tlp_blk_xfer_in_has_data    (tlp_blk_xfer_in_has_data),
    .tlp_blk_xfer_in_data_valid  (tlp_blk_xfer_in_data_valid),
    .tlp_blk_xfer_in_data_ready  (tlp_blk_xfer_in_data_ready),
    .tlp_blk_xfer_in_data_last   (tlp_blk_xfer_in_data_last),
    .tlp_blk_xfer_in_data        (tlp_blk_xfer_in_data),
    .tlp_blk_out_xfer            (tlp_blk_out_xfer),
    .tlp_blk_xfer_out_ready_read (tlp_blk_xfer_out_ready_read),
    .tlp_blk_xfer_out_data       (tlp_blk_xfer_out_data),
    .tlp_blk_xfer_out_data_valid (tlp_blk_xfer_out_data_valid),
    .ep_in_xfer                  (ep_in_xfer),
    .ep_in_has_data              (ep_in_has_data),
    .ep_in_tvalid                (ep_in_tvalid),
    .ep_in_tlast                 (ep_in_tlast),
    .ep_in_tready                (ep_in_tready),
    .ep_in_tdata                 (ep_in_tdata),
    .ep_out_xfer                 (ep_out_xfer),
    .ep_out_ready_read           (ep_out_ready_read),
    .ep_out_tvalid               (ep_out_tvalid),
    .ep_out_tlast                (ep_out_tlast),
    .ep_out_tready               (ep_out_tready),
    .ep_out_tdata                (ep_out_tdata),
    .out_overrun_o               (out_overrun_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {last, data} per IN source lane; expected {last, data} at the TLP side;
  // expected {lane, last, data} at the OUT endpoint side.
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] exp_in[$];
  logic [9:0] exp_out[$];

  logic [1:0] hs_in = 2'b00;
  int stray_rdy0 = 0;
  int stray_v0   = 0;
  int stray_v1   = 0;
  int out_vcyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IN endpoint models: offer the queue head, pop on handshake.
  always @(posedge clk) begin
    if (hs_in[0] && src0.size() > 0) void'(src0.pop_front());
    if (hs_in[1] && src1.size() > 0) void'(src1.pop_front());
    #1;
    ep_in_tvalid[0] = (src0.size() > 0);
    ep_in_tvalid[1] = (src1.size() > 0);
    if (src0.size() > 0) {ep_in_tlast[0], ep_in_tdata[7:0]}  = src0[0];
    else                 {ep_in_tlast[0], ep_in_tdata[7:0]}  = 9'h000;
    if (src1.size() > 0) {ep_in_tlast[1], ep_in_tdata[15:8]} = src1[0];
    else                 {ep_in_tlast[1], ep_in_tdata[15:8]} = 9'h000;
  end

  // Monitors sample half a cycle away from the active edge.
  always @(negedge clk) begin
    hs_in = ep_in_tvalid & ep_in_tready;
    if (ep_in_tready[0])  stray_rdy0++;
    if (ep_out_tvalid[0]) stray_v0++;
    if (ep_out_tvalid[1]) stray_v1++;
    if (|ep_out_tvalid)   out_vcyc++;

    if (tlp_blk_xfer_in_data_valid && tlp_blk_xfer_in_data_ready) begin
      if (exp_in.size() == 0) chk("in_extra_byte", 32'(exp_in.size()), 1);
      else begin
        logic [8:0] e;
        e = exp_in.pop_front();
        chk("in_beat", {tlp_blk_xfer_in_data_last, tlp_blk_xfer_in_data}, e);
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (ep_out_tvalid[k] && ep_out_tready[k]) begin
        logic ln;
        ln = k[0];
        if (exp_out.size() == 0) chk("out_extra_beat", 32'(exp_out.size()), 1);
        else begin
          logic [9:0] e;
          e = exp_out.pop_front();
          chk("out_beat", {ln, ep_out_tlast[k], ep_out_tdata}, e);
        end
      end
    end
  end

  task automatic wait_in_done(input int maxc);
    int n = 0;
    while (exp_in.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("in_pending_timeout", 32'(exp_in.size()), 0);
  endtask

  task automatic wait_out_done(input int maxc);
    int n = 0;
    while (exp_out.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("out_pending_timeout", 32'(exp_out.size()), 0);
  endtask

  // One OUT byte strobe; optionally recorded as an expected endpoint beat.
  task automatic strobe(input logic [7:0] d, input logic lane, input logic last, input logic expect_it);
    tlp_blk_xfer_out_data       = d;
    tlp_blk_xfer_out_data_valid = 1'b1;
    if (expect_it) exp_out.push_back({lane, last, d});
    tick();
    tlp_blk_xfer_out_data_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vbase;
    rst = 1'b1;
    blk_xfer_endpoint = 4'd0;
    tlp_blk_in_xfer = 1'b0;
    tlp_blk_out_xfer = 1'b0;
    tlp_blk_xfer_in_data_ready = 1'b0;
    tlp_blk_xfer_out_data = 8'h00;
    tlp_blk_xfer_out_data_valid = 1'b0;
    ep_in_has_data = 2'b00;
    ep_out_ready_read = 2'b00;
    ep_out_tready = 2'b11;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_xfer", ep_in_xfer, 0);
    chk("rst_out_xfer", ep_out_xfer, 0);
    chk("rst_out_tvalid", ep_out_tvalid, 0);
    chk("rst_out_tlast", ep_out_tlast, 0);
    chk("rst_overrun", out_overrun_o, 0);
    chk("rst_tlp_valid", tlp_blk_xfer_in_data_valid, 0);
    tick();
    rst = 1'b0;

    // Status decode
    blk_xfer_endpoint = 4'd2; ep_in_has_data = 2'b10; ep_out_ready_read = 2'b01; #1;
    chk("has_data_ep2", tlp_blk_xfer_in_has_data, 1);
    chk("ready_read_ep2", tlp_blk_xfer_out_ready_read, 0);
    blk_xfer_endpoint = 4'd1; #1;
    chk("has_data_ep1", tlp_blk_xfer_in_has_data, 0);
    chk("ready_read_ep1", tlp_blk_xfer_out_ready_read, 1);
    blk_xfer_endpoint = 4'd3; ep_in_has_data = 2'b11; ep_out_ready_read = 2'b11; #1;
    chk("has_data_ep3_unmapped", tlp_blk_xfer_in_has_data, 0);
    chk("ready_read_ep3_unmapped", tlp_blk_xfer_out_ready_read, 0);
    blk_xfer_endpoint = 4'd0; #1;
    chk("has_data_ep0_unmapped", tlp_blk_xfer_in_has_data, 0);

    // IN routing to ep2
    tick();
    blk_xfer_endpoint = 4'd2; ep_in_has_data = 2'b10;
    for (int i = 0; i < 4; i++) begin
      logic [8:0] b;
      b = {(i == 3), 8'hA0 + 8'(i)};
      src1.push_back(b);
      exp_in.push_back(b);
    end
    tlp_blk_xfer_in_data_ready = 1'b1;
    tlp_blk_in_xfer = 1'b1;
    stray_rdy0 = 0;
    @(negedge clk);
    chk("in_grant_before_sample", ep_in_xfer, 2'b00);
    @(negedge clk);
    chk("in_grant_ep2", ep_in_xfer, 2'b10);
    wait_in_done(40);
    tick();
    tlp_blk_in_xfer = 1'b0;
    @(negedge clk);
    chk("in_grant_until_sampled_low", ep_in_xfer, 2'b10);
    @(negedge clk);
    chk("in_grant_released", ep_in_xfer, 2'b00);
    chk("in_lane0_tready", stray_rdy0, 0);

    // OUT framing to ep1
    tick();
    blk_xfer_endpoint = 4'd1; ep_out_tready = 2'b11; tlp_blk_out_xfer = 1'b1;
    stray_v1 = 0;
    tick();
    strobe(8'h11, 1'b0, 1'b0, 1'b1);
    chk("out_grant_ep1", ep_out_xfer, 2'b01);
    strobe(8'h22, 1'b0, 1'b0, 1'b1);
    strobe(8'h33, 1'b0, 1'b1, 1'b1);
    tlp_blk_out_xfer = 1'b0;
    @(negedge clk);
    chk("out_tlast_not_yet", ep_out_tlast, 2'b00);
    @(negedge clk);
    chk("out_tlast_timing", ep_out_tlast, 2'b01);
    wait_out_done(20);
    chk("out_lane1_tvalid", stray_v1, 0);

    // Zero-length OUT
    tick();
    vbase = out_vcyc;
    tlp_blk_out_xfer = 1'b1;
    repeat (3) tick();
    tlp_blk_out_xfer = 1'b0;
    repeat (4) tick();
    chk("zlp_no_beats", out_vcyc - vbase, 0);

    // Unmapped IN token ep5 -> DROP
    blk_xfer_endpoint = 4'd5; ep_in_has_data = 2'b11;
    src0.push_back(9'h099);
    tlp_blk_in_xfer = 1'b1;
    @(negedge clk);
    chk("drop_has_data", tlp_blk_xfer_in_has_data, 0);
    tick();
    @(negedge clk);
    chk("drop_in_grant", ep_in_xfer, 2'b00);
    chk("drop_tlp_valid", tlp_blk_xfer_in_data_valid, 0);
    tick();
    tlp_blk_in_xfer = 1'b0;
    tick();

    // Priority and endpoint latch (also proves DROP returned to IDLE)
    src0.delete();
    blk_xfer_endpoint = 4'd1;
    src0.push_back(9'h0B0); exp_in.push_back(9'h0B0);
    src0.push_back(9'h1B1); exp_in.push_back(9'h1B1);
    tlp_blk_in_xfer = 1'b1; tlp_blk_out_xfer = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("prio_in_grant", ep_in_xfer, 2'b01);
    chk("prio_out_grant", ep_out_xfer, 2'b00);
    #1 blk_xfer_endpoint = 4'd2;
    repeat (2) @(negedge clk);
    chk("latch_in_grant", ep_in_xfer, 2'b01);
    wait_in_done(20);
    tick();
    tlp_blk_in_xfer = 1'b0; tlp_blk_out_xfer = 1'b0;
    repeat (2) tick();

    // Overrun with ep1 stalled
    blk_xfer_endpoint = 4'd1; ep_out_tready = 2'b00;
    chk("overrun_before", out_overrun_o, 0);
    tlp_blk_out_xfer = 1'b1;
    tick();
    strobe(8'h44, 1'b0, 1'b0, 1'b1);
    strobe(8'h55, 1'b0, 1'b0, 1'b0);
    strobe(8'h66, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("overrun_set", out_overrun_o, 1);
    tick();
    ep_out_tready = 2'b11; tlp_blk_out_xfer = 1'b0;
    wait_out_done(20);
    repeat (3) tick();
    chk("overrun_sticky", out_overrun_o, 1);

    // Reset during IN after 2 of 4 bytes
    blk_xfer_endpoint = 4'd1; tlp_blk_xfer_in_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [8:0] b;
      b = {(i == 3), 8'hC0 + 8'(i)};
      src0.push_back(b);
      if (i < 2) exp_in.push_back(b);
    end
    tlp_blk_in_xfer = 1'b1;
    tick();
    tlp_blk_xfer_in_data_ready = 1'b1;
    repeat (2) tick();
    tlp_blk_xfer_in_data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_grant", ep_in_xfer, 2'b00);
    chk("rst_mid_out_grant", ep_out_xfer, 2'b00);
    chk("rst_mid_tlp_valid", tlp_blk_xfer_in_data_valid, 0);
    chk("rst_mid_overrun_clr", out_overrun_o, 0);
    chk("rst_mid_bytes_seen", 32'(exp_in.size()), 0);
    tick();
    rst = 1'b0; tlp_blk_in_xfer = 1'b0;
    src0.delete();
    tick();

    // OUT to ep2 after reset
    blk_xfer_endpoint = 4'd2; ep_out_tready = 2'b11; tlp_blk_out_xfer = 1'b1;
    stray_v0 = 0;
    tick();
    strobe(8'h77, 1'b1, 1'b0, 1'b1);
    chk("out2_grant", ep_out_xfer, 2'b10);
    strobe(8'h88, 1'b1, 1'b1, 1'b1);
    tlp_blk_out_xfer = 1'b0;
    wait_out_done(20);
    chk("out2_lane0_tvalid", stray_v0, 0);
    chk("out2_overrun", out_overrun_o, 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
